nonce_hub_fifo: RTL and testbench

- Parametrised successor to the miner hub core. Collects golden nonces from SLAVES sources (local hashcores and external slave_receive ports) in the uart_clk domain.
- Buffers them in a shared FIFO using round-robin fairness, counts lost nonces, and feeds serial_transmit one 32-bit word at a time.
- Sits between the per-slave clock-domain-crossing toggles and serial_transmit.

---
 rtl/nonce_hub_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_nonce_hub_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_hub_fifo.sv
// nonce_hub_fifo: collects golden nonces from SLAVES sources, arbitrates them
// round-robin into a shared FIFO, counts lost nonces and hands words one at a
// time to serial_transmit. Single clock domain (uart_clk).
// Optional build macro: NONCE_DUP_FILTER_EN drops a strobe whose value repeats
// the last nonce accepted from the same slave.
module nonce_hub_fifo #(
  parameter int unsigned SLAVES     = 3,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OVF_BITS   = 8
) (
  input  logic                          uart_clk,
  input  logic                          reset_n,
  input  logic [SLAVES*32-1:0]          slave_nonces,
  input  logic [SLAVES-1:0]             new_nonces,
  input  logic                          serial_busy,
  output logic [31:0]                   golden_nonce,
  output logic                          serial_send,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [OVF_BITS-1:0]           ovf_count,
  output logic                          nonce_seen
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(SLAVES - 1);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_WAIT_HI,
    TX_WAIT_LO
  } tx_state_e;

  // Capture stage state
  logic [31:0]         hold_q [SLAVES];
  logic [SLAVES-1:0]   pend_q;
  logic [SLAVES-1:0]   cap;
  logic                seen_q;
  logic [OVF_BITS-1:0] ovf_q, ovf_d;

  // Arbiter
  logic [PW-1:0]       rr_q, rr_d;
  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic [SLAVES-1:0]   gnt_oh;
  logic [31:0]         push_data;

  // FIFO
  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                fifo_full;
  logic                push, pop;

  // TX FSM
  tx_state_e           state_q;
  logic [31:0]         golden_q;
  logic                send_q;
  logic [1:0]          hi_cnt_q;

`ifdef NONCE_DUP_FILTER_EN
  logic [31:0]         last_q [SLAVES];
  logic [SLAVES-1:0]   last_vld_q;

  // A strobe is accepted unless it repeats the last value accepted from that slave
  always_comb begin
    cap = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      cap[i] = new_nonces[i] &&
               !(last_vld_q[i] && (last_q[i] == slave_nonces[i*32 +: 32]));
    end
  end

  // Remember the most recently accepted nonce per slave
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SLAVES; i++) begin
        last_q[i] <= '0;
      end
      last_vld_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SLAVES; i++) begin
        if (cap[i]) begin
          last_q[i]     <= slave_nonces[i*32 +: 32];
          last_vld_q[i] <= 1'b1;
        end
      end
    end
  end
`else
  // Every strobe is accepted
  always_comb begin
    cap = new_nonces;
  end
`endif

  assign fifo_full = (cnt_q == FULL_CNT);

  // Round-robin grant: first pending slave at or after rr_q, then wrap below it
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!fifo_full) begin
      for (int unsigned i = 0; i < SLAVES; i++) begin
        if (!gnt_vld && pend_q[i] && (PW'(i) >= rr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
      for (int unsigned i = 0; i < SLAVES; i++) begin
        if (!gnt_vld && pend_q[i] && (PW'(i) < rr_q)) begin
          gnt_vld = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
    rr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
  end

  // Decode the grant and select the holding register to push
  always_comb begin
    gnt_oh    = '0;
    push_data = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (gnt_vld && (gnt_idx == PW'(i))) begin
        gnt_oh[i] = 1'b1;
        push_data = hold_q[i];
      end
    end
  end

  // Lost nonces: a capture lands on a pending slot that is not being drained
  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (cap[i] && pend_q[i] && !gnt_oh[i] && (ovf_d != '1)) begin
        ovf_d = ovf_d + OVF_BITS'(1);
      end
    end
  end

  // Capture registers, pending flags, rr pointer and overflow counter.
  // A capture on a slave granted in the same cycle keeps pending set: the old
  // value leaves via the push while the new one takes its place.
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SLAVES; i++) begin
        hold_q[i] <= '0;
      end
      pend_q <= '0;
      rr_q   <= '0;
      ovf_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SLAVES; i++) begin
        if (cap[i]) begin
          hold_q[i] <= slave_nonces[i*32 +: 32];
        end
        pend_q[i] <= cap[i] | (pend_q[i] & ~gnt_oh[i]);
      end
      if (gnt_vld) begin
        rr_q <= rr_d;
      end
      ovf_q  <= ovf_d;
      seen_q <= |cap;
    end
  end

  assign push = gnt_vld;
  assign pop  = (state_q == TX_IDLE) && (cnt_q != '0) && !serial_busy;

  // Occupancy next state; a push against a full FIFO is never granted
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO storage; contents are discarded on reset through the pointers
  always_ff @(posedge uart_clk) begin
    if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  // TX handshake with serial_transmit; WAIT_HI times out after 4 cycles
  always_ff @(posedge uart_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= TX_IDLE;
      golden_q <= '0;
      send_q   <= 1'b0;
      hi_cnt_q <= '0;
    end else begin
      unique case (state_q)
        TX_IDLE: begin
          if (pop) begin
            golden_q <= mem_q[rd_q];
            send_q   <= 1'b1;
            state_q  <= TX_SEND;
          end
        end
        TX_SEND: begin
          send_q   <= 1'b0;
          hi_cnt_q <= '0;
          state_q  <= TX_WAIT_HI;
        end
        TX_WAIT_HI: begin
          if (serial_busy || (hi_cnt_q == 2'd3)) begin
            state_q <= TX_WAIT_LO;
          end else begin
            hi_cnt_q <= hi_cnt_q + 2'd1;
          end
        end
        TX_WAIT_LO: begin
          if (!serial_busy) begin
            state_q <= TX_IDLE;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign golden_nonce = golden_q;
  assign serial_send  = send_q;
  assign fifo_count   = cnt_q;
  assign ovf_count    = ovf_q;
  assign nonce_seen   = seen_q;

endmodule

// File: tb/tb_nonce_hub_fifo.sv
// Directed bench for nonce_hub_fifo (SLAVES=3, FIFO_DEPTH=4). Expected nonces
// are queued as stimulus is driven and compared in order at each serial_send.
module tb_nonce_hub_fifo;

  localparam int unsigned SLAVES = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OVFB   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic [SLAVES*32-1:0] nonces = '0;
  logic [SLAVES-1:0]    strb = '0;
  logic                 busy = 1'b0;
  logic [31:0]          golden_nonce;
  logic                 serial_send;
  logic [2:0]           fifo_count;
  logic [OVFB-1:0]      ovf_count;
  logic                 nonce_seen;

  int checks = 0;
  int errors = 0;
  int send_cnt = 0;
  int seen_cnt = 0;
  logic [31:0] exp_q [$];

  nonce_hub_fifo #(
    .SLAVES     (SLAVES),
    .FIFO_DEPTH (DEPTH),
    .OVF_BITS   (OVFB)
  ) dut (
    .uart_clk     (clk),
    .reset_n      (rst_n),
    .slave_nonces (nonces),
    .new_nonces   (strb),
    .serial_busy  (busy),
    .golden_nonce (golden_nonce),
    .serial_send  (serial_send),
    .fifo_count   (fifo_count),
    .ovf_count    (ovf_count),
    .nonce_seen   (nonce_seen)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic strobe1(input int s, input logic [31:0] v);
    nonces[s*32 +: 32] = v;
    strb[s] = 1'b1;
    tick();
    strb = '0;
  endtask

  task automatic strobe3(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    nonces = {v2, v1, v0};
    strb = '1;
    tick();
    strb = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    busy = 1'b0;
    strb = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_count != 0) && n < 500) begin
      tick();
      n++;
    end
    repeat (12) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every send must match the oldest expected nonce
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (nonce_seen === 1'b1) seen_cnt++;
      if (serial_send === 1'b1) begin
        send_cnt++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_send observed=0x%08h expected=no_send", golden_nonce);
        end
        if (exp_q.size() > 0) chk("send_order", golden_nonce, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int z0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_golden", golden_nonce, 32'd0);
    chk("rst_send", 32'(serial_send), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(ovf_count), 32'd0);
    chk("rst_seen", 32'(nonce_seen), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single nonce on slave 1, 2-cycle strobe-to-FIFO latency
    s0 = send_cnt; z0 = seen_cnt;
    exp_q.push_back(32'hDEADBEEF);
    strobe1(1, 32'hDEADBEEF);
    chk("seen_pulse", 32'(nonce_seen), 32'd1);
    chk("count_after_capture", 32'(fifo_count), 32'd0);
    tick();
    chk("latency_count", 32'(fifo_count), 32'd1);
    drain("single_drain");
    chk("single_sends", 32'(send_cnt - s0), 32'd1);
    chk("single_seen", 32'(seen_cnt - z0), 32'd1);
    chk("single_ovf", 32'(ovf_count), 32'd0);

    // Simultaneous strobes from rr_ptr = 0: order 0,1,2
    do_reset();
    exp_q.push_back(32'h00000010);
    exp_q.push_back(32'h10000020);
    exp_q.push_back(32'h20000030);
    strobe3(32'h00000010, 32'h10000020, 32'h20000030);
    drain("rr0_drain");
    // Grant slave 1 alone so rr_ptr becomes 2, then expect order 2,0,1
    exp_q.push_back(32'hAAAA0001);
    strobe1(1, 32'hAAAA0001);
    drain("rr_prep_drain");
    exp_q.push_back(32'h20000031);
    exp_q.push_back(32'h00000011);
    exp_q.push_back(32'h10000021);
    strobe3(32'h00000011, 32'h10000021, 32'h20000031);
    drain("rr2_drain");
    chk("rr_ovf", 32'(ovf_count), 32'd0);

    // FIFO full with busy held: 4 queued, 5th pending, 6th overwrites it
    do_reset();
    busy = 1'b1;
    s0 = send_cnt;
    for (int k = 1; k <= 6; k++) begin
      if (k != 5) exp_q.push_back(32'hF0000000 + 32'(k));
      strobe1(0, 32'hF0000000 + 32'(k));
      repeat (3) tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ovf", 32'(ovf_count), 32'd1);
    chk("full_no_send", 32'(send_cnt - s0), 32'd0);
    busy = 1'b0;
    drain("full_drain");
    chk("full_sends", 32'(send_cnt - s0), 32'd5);

    // Same-slave capture and grant in one cycle: A then B both delivered
    do_reset();
    exp_q.push_back(32'hA0A0A0A0);
    exp_q.push_back(32'hB0B0B0B0);
    strobe1(2, 32'hA0A0A0A0);
    strobe1(2, 32'hB0B0B0B0);
    drain("samecycle_drain");
    chk("samecycle_ovf", 32'(ovf_count), 32'd0);

    // Reset while in WAIT_LO with 3 entries queued
    do_reset();
    exp_q.push_back(32'hC0000000);
    strobe1(0, 32'hC0000000);
    strobe1(0, 32'hC0000001);
    strobe1(0, 32'hC0000002);
    strobe1(0, 32'hC0000003);
    busy = 1'b1;
    repeat (4) tick();
    chk("midburst_count", 32'(fifo_count), 32'd3);
    chk("midburst_sent", 32'(exp_q.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_golden", golden_nonce, 32'd0);
    chk("midrst_send", 32'(serial_send), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_ovf", 32'(ovf_count), 32'd0);
    tick();
    rst_n = 1'b1;
    busy = 1'b0;
    s0 = send_cnt;
    repeat (30) tick();
    chk("postrst_sends", 32'(send_cnt - s0), 32'd0);
    chk("postrst_count", 32'(fifo_count), 32'd0);

    // Repeated values on slave 0
    do_reset();
    s0 = send_cnt; z0 = seen_cnt;
    exp_q.push_back(32'h12345678);
    strobe1(0, 32'h12345678);
    repeat (10) tick();
`ifndef NONCE_DUP_FILTER_EN
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
`endif
    strobe1(0, 32'h12345678);
    repeat (10) tick();
    strobe1(0, 32'h12345678);
    repeat (10) tick();
    exp_q.push_back(32'h12345679);
    strobe1(0, 32'h12345679);
    drain("dup_drain");
`ifdef NONCE_DUP_FILTER_EN
    chk("dup_sends", 32'(send_cnt - s0), 32'd2);
    chk("dup_seen", 32'(seen_cnt - z0), 32'd2);
`else
    chk("dup_sends", 32'(send_cnt - s0), 32'd4);
    chk("dup_seen", 32'(seen_cnt - z0), 32'd4);
`endif
    chk("dup_ovf", 32'(ovf_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
